// File: rtl/snoop_bus_arbiter_pkg.sv
// Shared types for the snoop bus arbiter: bus ops, MOESI L1 states and the peer snoop transition.
// Line/address widths come from `ADDR_BITS, `OFFSET_BITS and `CACHELINE_BITS (defaults below).
`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif
`ifndef OFFSET_BITS
`define OFFSET_BITS 6
`endif
`ifndef CACHELINE_BITS
`define CACHELINE_BITS 512
`endif

package snoop_bus_arbiter_pkg;

    localparam int LINE_ADDR_BITS = `ADDR_BITS - `OFFSET_BITS;
    localparam int CACHELINE_BITS = `CACHELINE_BITS;

    typedef enum logic [1:0] {
        BUS_RD,
        BUS_RDX,
        BUS_UPGR,
        BUS_WB
    } bus_req_t;

    typedef enum logic [2:0] {
        L1_I,
        L1_S,
        L1_E,
        L1_O,
        L1_M
    } l1_state_t;

    // A read leaves dirty data with the old holder as owner; exclusive ops invalidate peers.
    function automatic l1_state_t peer_next_state(input bus_req_t op, input l1_state_t state);
        l1_state_t nxt;
        nxt = state;
        case (op)
            BUS_RD: begin
                case (state)
                    L1_M:    nxt = L1_O;
                    L1_E:    nxt = L1_S;
                    default: nxt = state;
                endcase
            end
            BUS_RDX, BUS_UPGR: nxt = L1_I;
            default:           nxt = state;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/snoop_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping upward.
module rr_arbiter
    import snoop_bus_arbiter_pkg::*;
#(
    parameter int NUM_CORES    = 4,
    parameter int CORE_ID_BITS = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0]    req,
    input  logic [CORE_ID_BITS-1:0] ptr,
    input  logic                    advance,
    output logic [CORE_ID_BITS-1:0] grant_idx,
    output logic                    grant_valid
);

    logic [CORE_ID_BITS:0]   sum;
    logic [CORE_ID_BITS-1:0] idx;

    // Scan offsets from the far end so the nearest requester is the last one written.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int off = NUM_CORES - 1; off >= 0; off--) begin
            sum = {1'b0, ptr} + (CORE_ID_BITS + 1)'(off);
            if (sum >= (CORE_ID_BITS + 1)'(NUM_CORES)) begin
                sum = sum - (CORE_ID_BITS + 1)'(NUM_CORES);
            end
            idx = sum[CORE_ID_BITS-1:0];
            if (req[idx]) begin
                grant_idx   = idx;
                grant_valid = advance;
            end
        end
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Coherence bus arbiter: grants one L1 request at a time, snoops peers, sources fills from owner or memory.
// Optional BUS_STATS_EN adds saturating transaction/cache-to-cache/memory-read counters.
module snoop_bus_arbiter
    import snoop_bus_arbiter_pkg::*;
#(
    parameter int NUM_CORES    = 4,
    parameter int CORE_ID_BITS = $clog2(NUM_CORES)
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic      [NUM_CORES-1:0]                     bus_req_valid,
    output logic      [NUM_CORES-1:0]                     bus_req_ready,
    input  logic      [NUM_CORES-1:0][LINE_ADDR_BITS-1:0] bus_req_addr,
    input  bus_req_t  [NUM_CORES-1:0]                     bus_req,
    input  logic      [NUM_CORES-1:0][CACHELINE_BITS-1:0] bus_req_data,
    output logic      [NUM_CORES-1:0]                     bus_resp_valid,
    output logic      [CACHELINE_BITS-1:0]                bus_resp_data,
    output logic                                          bus_resp_shared,
    output logic                                          snoop_valid,
    output logic      [LINE_ADDR_BITS-1:0]                snoop_addr,
    input  l1_state_t [NUM_CORES-1:0]                     snoop_state,
    input  logic      [NUM_CORES-1:0][CACHELINE_BITS-1:0] snoop_data,
    output logic      [NUM_CORES-1:0]                     snoop_update,
    output l1_state_t [NUM_CORES-1:0]                     snoop_next_state,
    output logic                                          mem_req_valid,
    input  logic                                          mem_req_ready,
    output logic                                          mem_req_write,
    output logic      [LINE_ADDR_BITS-1:0]                mem_req_addr,
    output logic      [CACHELINE_BITS-1:0]                mem_req_data,
    input  logic                                          mem_resp_valid,
    input  logic      [CACHELINE_BITS-1:0]                mem_resp_data
`ifdef BUS_STATS_EN
    ,
    output logic      [31:0]                              stat_txn,
    output logic      [31:0]                              stat_c2c,
    output logic      [31:0]                              stat_mem_rd
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        SNOOP,
        MEM_REQ,
        MEM_WAIT,
        RESPOND
    } state_t;

    state_t                    state_q, state_d;
    logic [CORE_ID_BITS-1:0]   ptr_q, ptr_d;
    logic [CORE_ID_BITS-1:0]   gnt_q, gnt_d;
    logic [LINE_ADDR_BITS-1:0] addr_q, addr_d;
    bus_req_t                  op_q, op_d;
    logic [CACHELINE_BITS-1:0] wdata_q, wdata_d;
    logic                      shared_q, shared_d;
    logic [CACHELINE_BITS-1:0] resp_data_q, resp_data_d;
    logic                      resp_shared_q, resp_shared_d;

    logic                    advance;
    logic [CORE_ID_BITS-1:0] grant_idx;
    logic                    grant_valid;
    logic                    owner_found;
    logic [CORE_ID_BITS-1:0] owner_idx;
    logic                    any_peer;

    // Gating with reset keeps the ready pulse quiet while reset is held.
    assign advance = (state_q == IDLE) && !reset;

    rr_arbiter #(
        .NUM_CORES   (NUM_CORES),
        .CORE_ID_BITS(CORE_ID_BITS)
    ) u_rr_arbiter (
        .req        (bus_req_valid),
        .ptr        (ptr_q),
        .advance    (advance),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    always_comb begin
        owner_found = 1'b0;
        owner_idx   = '0;
        any_peer    = 1'b0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (CORE_ID_BITS'(i) != gnt_q) begin
                if (snoop_state[i] != L1_I) begin
                    any_peer = 1'b1;
                end
                if (snoop_state[i] == L1_M || snoop_state[i] == L1_O) begin
                    owner_found = 1'b1;
                    owner_idx   = CORE_ID_BITS'(i);
                end
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        gnt_d            = gnt_q;
        addr_d           = addr_q;
        op_d             = op_q;
        wdata_d          = wdata_q;
        shared_d         = shared_q;
        resp_data_d      = resp_data_q;
        resp_shared_d    = resp_shared_q;
        bus_req_ready    = '0;
        bus_resp_valid   = '0;
        snoop_valid      = 1'b0;
        snoop_addr       = '0;
        snoop_update     = '0;
        mem_req_valid    = 1'b0;
        mem_req_write    = 1'b0;
        mem_req_addr     = '0;
        mem_req_data     = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            snoop_next_state[i] = L1_I;
        end

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    bus_req_ready[grant_idx] = 1'b1;
                    gnt_d   = grant_idx;
                    addr_d  = bus_req_addr[grant_idx];
                    op_d    = bus_req[grant_idx];
                    wdata_d = bus_req_data[grant_idx];
                    ptr_d   = (grant_idx == CORE_ID_BITS'(NUM_CORES - 1)) ? '0
                                                                           : grant_idx + CORE_ID_BITS'(1);
                    state_d = (bus_req[grant_idx] == BUS_WB) ? MEM_REQ : SNOOP;
                end
            end
            SNOOP: begin
                snoop_valid = 1'b1;
                snoop_addr  = addr_q;
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (CORE_ID_BITS'(i) != gnt_q) begin
                        snoop_update[i]     = 1'b1;
                        snoop_next_state[i] = peer_next_state(op_q, snoop_state[i]);
                    end
                end
                shared_d = (op_q == BUS_RD) && any_peer;
                if (op_q == BUS_UPGR) begin
                    state_d = IDLE;
                end else if (owner_found) begin
                    resp_data_d   = snoop_data[owner_idx];
                    resp_shared_d = (op_q == BUS_RD) && any_peer;
                    state_d       = RESPOND;
                end else begin
                    state_d = MEM_REQ;
                end
            end
            MEM_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_write = (op_q == BUS_WB);
                mem_req_addr  = addr_q;
                mem_req_data  = wdata_q;
                if (mem_req_ready) begin
                    state_d = (op_q == BUS_WB) ? IDLE : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_resp_valid) begin
                    resp_data_d   = mem_resp_data;
                    resp_shared_d = shared_q;
                    state_d       = RESPOND;
                end
            end
            RESPOND: begin
                bus_resp_valid[gnt_q] = 1'b1;
                state_d               = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            gnt_q         <= '0;
            addr_q        <= '0;
            op_q          <= BUS_RD;
            wdata_q       <= '0;
            shared_q      <= 1'b0;
            resp_data_q   <= '0;
            resp_shared_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            gnt_q         <= gnt_d;
            addr_q        <= addr_d;
            op_q          <= op_d;
            wdata_q       <= wdata_d;
            shared_q      <= shared_d;
            resp_data_q   <= resp_data_d;
            resp_shared_q <= resp_shared_d;
        end
    end

    assign bus_resp_data   = resp_data_q;
    assign bus_resp_shared = resp_shared_q;

`ifdef BUS_STATS_EN
    logic [31:0] stat_txn_q, stat_txn_d;
    logic [31:0] stat_c2c_q, stat_c2c_d;
    logic [31:0] stat_mem_rd_q, stat_mem_rd_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        stat_txn_d    = stat_txn_q;
        stat_c2c_d    = stat_c2c_q;
        stat_mem_rd_d = stat_mem_rd_q;
        if (advance && grant_valid && stat_txn_q != '1) begin
            stat_txn_d = stat_txn_q + 32'd1;
        end
        if (state_q == SNOOP && op_q != BUS_UPGR && owner_found && stat_c2c_q != '1) begin
            stat_c2c_d = stat_c2c_q + 32'd1;
        end
        if (state_q == MEM_REQ && mem_req_ready && op_q != BUS_WB && stat_mem_rd_q != '1) begin
            stat_mem_rd_d = stat_mem_rd_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_txn_q    <= '0;
            stat_c2c_q    <= '0;
            stat_mem_rd_q <= '0;
        end else begin
            stat_txn_q    <= stat_txn_d;
            stat_c2c_q    <= stat_c2c_d;
            stat_mem_rd_q <= stat_mem_rd_d;
        end
    end

    assign stat_txn    = stat_txn_q;
    assign stat_c2c    = stat_c2c_q;
    assign stat_mem_rd = stat_mem_rd_q;
`endif

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: memory fill, owner fill, RDX/UPGR, round-robin, write-back stall, reset abandon.
module tb_snoop_bus_arbiter;
    import snoop_bus_arbiter_pkg::*;

    localparam int N = 4;

    logic                                  clk;
    logic                                  reset;
    logic      [N-1:0]                     bus_req_valid;
    logic      [N-1:0]                     bus_req_ready;
    logic      [N-1:0][LINE_ADDR_BITS-1:0] bus_req_addr;
    bus_req_t  [N-1:0]                     bus_req;
    logic      [N-1:0][CACHELINE_BITS-1:0] bus_req_data;
    logic      [N-1:0]                     bus_resp_valid;
    logic      [CACHELINE_BITS-1:0]        bus_resp_data;
    logic                                  bus_resp_shared;
    logic                                  snoop_valid;
    logic      [LINE_ADDR_BITS-1:0]        snoop_addr;
    l1_state_t [N-1:0]                     snoop_state;
    logic      [N-1:0][CACHELINE_BITS-1:0] snoop_data;
    logic      [N-1:0]                     snoop_update;
    l1_state_t [N-1:0]                     snoop_next_state;
    logic                                  mem_req_valid;
    logic                                  mem_req_ready;
    logic                                  mem_req_write;
    logic      [LINE_ADDR_BITS-1:0]        mem_req_addr;
    logic      [CACHELINE_BITS-1:0]        mem_req_data;
    logic                                  mem_resp_valid;
    logic      [CACHELINE_BITS-1:0]        mem_resp_data;
`ifdef BUS_STATS_EN
    logic      [31:0]                      stat_txn;
    logic      [31:0]                      stat_c2c;
    logic      [31:0]                      stat_mem_rd;
`endif

    int checkCount = 0;
    int passCount  = 0;

    localparam logic [CACHELINE_BITS-1:0] DATA_AA = {(CACHELINE_BITS / 8){8'hAA}};
    localparam logic [CACHELINE_BITS-1:0] DATA_55 = {(CACHELINE_BITS / 8){8'h55}};
    localparam logic [CACHELINE_BITS-1:0] DATA_33 = {(CACHELINE_BITS / 8){8'h33}};
    localparam logic [CACHELINE_BITS-1:0] DATA_12 = {(CACHELINE_BITS / 8){8'h12}};
    localparam logic [CACHELINE_BITS-1:0] DATA_FF = {(CACHELINE_BITS / 8){8'hFF}};

    snoop_bus_arbiter #(.NUM_CORES(N)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus_req_valid   (bus_req_valid),
        .bus_req_ready   (bus_req_ready),
        .bus_req_addr    (bus_req_addr),
        .bus_req         (bus_req),
        .bus_req_data    (bus_req_data),
        .bus_resp_valid  (bus_resp_valid),
        .bus_resp_data   (bus_resp_data),
        .bus_resp_shared (bus_resp_shared),
        .snoop_valid     (snoop_valid),
        .snoop_addr      (snoop_addr),
        .snoop_state     (snoop_state),
        .snoop_data      (snoop_data),
        .snoop_update    (snoop_update),
        .snoop_next_state(snoop_next_state),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_write   (mem_req_write),
        .mem_req_addr    (mem_req_addr),
        .mem_req_data    (mem_req_data),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data)
`ifdef BUS_STATS_EN
        ,
        .stat_txn        (stat_txn),
        .stat_c2c        (stat_c2c),
        .stat_mem_rd     (stat_mem_rd)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [CACHELINE_BITS-1:0] observed,
                               input logic [CACHELINE_BITS-1:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input int core, input bus_req_t op,
                                 input logic [LINE_ADDR_BITS-1:0] addr,
                                 input logic [CACHELINE_BITS-1:0] data);
        bus_req_valid[core] = 1'b1;
        bus_req[core]       = op;
        bus_req_addr[core]  = addr;
        bus_req_data[core]  = data;
    endtask

    task automatic setPeers(input l1_state_t s3, input l1_state_t s2,
                            input l1_state_t s1, input l1_state_t s0);
        snoop_state[3] = s3;
        snoop_state[2] = s2;
        snoop_state[1] = s1;
        snoop_state[0] = s0;
    endtask

    initial begin
        reset          = 1'b1;
        bus_req_valid  = '0;
        bus_req_addr   = '0;
        bus_req_data   = '0;
        for (int i = 0; i < N; i++) begin
            bus_req[i]     = BUS_RD;
            snoop_state[i] = L1_I;
        end
        snoop_data     = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;

        // Reset state with a request pending: nothing may be accepted.
        step();
        applyStimulus(2, BUS_RD, 'h10, '0);
        #1;
        checkOutput("rst_ready", N'(bus_req_ready), '0);
        checkOutput("rst_snoop_valid", snoop_valid, 1'b0);
        checkOutput("rst_mem_valid", mem_req_valid, 1'b0);
        checkOutput("rst_resp_valid", N'(bus_resp_valid), '0);
        checkOutput("rst_resp_data", bus_resp_data, '0);
        checkOutput("rst_resp_shared", bus_resp_shared, 1'b0);
        bus_req_valid[2] = 1'b0;
        step();
        reset = 1'b0;
        step();

        // Core0 read miss, all peers invalid, memory fill.
        $display("[TB] core0 BUS_RD memory fill");
        applyStimulus(0, BUS_RD, 'h40, '0);
        setPeers(L1_I, L1_I, L1_I, L1_I);
        #1;
        checkOutput("t1_ready", N'(bus_req_ready), N'(4'b0001));
        step();
        bus_req_valid[0] = 1'b0;
        #1;
        checkOutput("t1_snoop_valid", snoop_valid, 1'b1);
        checkOutput("t1_snoop_addr", snoop_addr, 'h40);
        checkOutput("t1_snoop_update", N'(snoop_update), N'(4'b1110));
        checkOutput("t1_next_state", snoop_next_state, '0);
        step();
        mem_req_ready = 1'b1;
        #1;
        checkOutput("t1_mem_valid", mem_req_valid, 1'b1);
        checkOutput("t1_mem_write", mem_req_write, 1'b0);
        checkOutput("t1_mem_addr", mem_req_addr, 'h40);
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = DATA_AA;
        #1;
        checkOutput("t1_wait_no_resp", N'(bus_resp_valid), '0);
        step();
        mem_resp_valid = 1'b0;
        #1;
        checkOutput("t1_resp_valid", N'(bus_resp_valid), N'(4'b0001));
        checkOutput("t1_resp_data", bus_resp_data, DATA_AA);
        checkOutput("t1_resp_shared", bus_resp_shared, 1'b0);
        step();
        #1;
        checkOutput("t1_resp_drop", N'(bus_resp_valid), '0);
        checkOutput("t1_resp_hold", bus_resp_data, DATA_AA);

        // Core1 read hits dirty copy in core0: cache-to-cache at cycle 2.
        $display("[TB] core1 BUS_RD owner fill");
        applyStimulus(1, BUS_RD, 'h40, '0);
        setPeers(L1_I, L1_I, L1_I, L1_M);
        snoop_data[0] = DATA_55;
        #1;
        checkOutput("t2_ready", N'(bus_req_ready), N'(4'b0010));
        step();
        bus_req_valid[1] = 1'b0;
        #1;
        checkOutput("t2_snoop_update", N'(snoop_update), N'(4'b1101));
        checkOutput("t2_core0_to_O", snoop_next_state[0], L1_O);
        checkOutput("t2_no_mem", mem_req_valid, 1'b0);
        step();
        #1;
        checkOutput("t2_resp_valid", N'(bus_resp_valid), N'(4'b0010));
        checkOutput("t2_resp_data", bus_resp_data, DATA_55);
        checkOutput("t2_resp_shared", bus_resp_shared, 1'b1);
        checkOutput("t2_no_mem_resp", mem_req_valid, 1'b0);
        step();
        setPeers(L1_I, L1_I, L1_I, L1_I);
        snoop_data[0] = '0;

        // Core2 read-exclusive over two sharers, then core3 upgrade.
        $display("[TB] core2 BUS_RDX, core3 BUS_UPGR");
        applyStimulus(2, BUS_RDX, 'h80, '0);
        setPeers(L1_I, L1_I, L1_S, L1_S);
        #1;
        checkOutput("t3_ready", N'(bus_req_ready), N'(4'b0100));
        step();
        bus_req_valid[2] = 1'b0;
        #1;
        checkOutput("t3_snoop_update", N'(snoop_update), N'(4'b1011));
        checkOutput("t3_next_state", snoop_next_state, '0);
        step();
        mem_req_ready = 1'b1;
        #1;
        checkOutput("t3_mem_valid", mem_req_valid, 1'b1);
        checkOutput("t3_mem_addr", mem_req_addr, 'h80);
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = DATA_33;
        step();
        mem_resp_valid = 1'b0;
        #1;
        checkOutput("t3_resp_valid", N'(bus_resp_valid), N'(4'b0100));
        checkOutput("t3_resp_data", bus_resp_data, DATA_33);
        checkOutput("t3_resp_shared", bus_resp_shared, 1'b0);
        step();
        applyStimulus(3, BUS_UPGR, 'h80, '0);
        setPeers(L1_I, L1_S, L1_S, L1_S);
        #1;
        checkOutput("t3u_ready", N'(bus_req_ready), N'(4'b1000));
        step();
        bus_req_valid[3] = 1'b0;
        #1;
        checkOutput("t3u_snoop_update", N'(snoop_update), N'(4'b0111));
        checkOutput("t3u_next_state", snoop_next_state, '0);
        step();
        #1;
        checkOutput("t3u_no_resp", N'(bus_resp_valid), '0);
        checkOutput("t3u_no_mem", mem_req_valid, 1'b0);
        setPeers(L1_I, L1_I, L1_I, L1_I);

        // Everybody requests at once: round-robin 0,1,2,3 (upgrades keep each grant short).
        $display("[TB] round-robin");
        for (int c = 0; c < N; c++) applyStimulus(c, BUS_UPGR, LINE_ADDR_BITS'(c), '0);
        #1;
        checkOutput("rr_g0", N'(bus_req_ready), N'(4'b0001));
        step();
        bus_req_valid[0] = 1'b0;
        step();
        checkOutput("rr_g1", N'(bus_req_ready), N'(4'b0010));
        step();
        bus_req_valid[1] = 1'b0;
        step();
        checkOutput("rr_g2", N'(bus_req_ready), N'(4'b0100));
        step();
        bus_req_valid[2] = 1'b0;
        step();
        checkOutput("rr_g3", N'(bus_req_ready), N'(4'b1000));
        step();
        bus_req_valid[3] = 1'b0;
        step();
        applyStimulus(1, BUS_UPGR, 'h1, '0);
        applyStimulus(3, BUS_UPGR, 'h3, '0);
        #1;
        checkOutput("rr2_g1", N'(bus_req_ready), N'(4'b0010));
        step();
        bus_req_valid[1] = 1'b0;
        step();
        checkOutput("rr2_g3", N'(bus_req_ready), N'(4'b1000));
        step();
        bus_req_valid[3] = 1'b0;
        step();

        // Write-back stalled by memory for three cycles.
        $display("[TB] core0 BUS_WB with stall");
        applyStimulus(0, BUS_WB, 'hC0, DATA_12);
        #1;
        checkOutput("wb_ready", N'(bus_req_ready), N'(4'b0001));
        step();
        bus_req_valid[0] = 1'b0;
        bus_req_data[0]  = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("wb_stall_valid", mem_req_valid, 1'b1);
            checkOutput("wb_stall_write", mem_req_write, 1'b1);
            checkOutput("wb_stall_addr", mem_req_addr, 'hC0);
            checkOutput("wb_stall_data", mem_req_data, DATA_12);
            checkOutput("wb_no_snoop", snoop_valid, 1'b0);
            step();
        end
        mem_req_ready = 1'b1;
        #1;
        checkOutput("wb_accept_valid", mem_req_valid, 1'b1);
        step();
        mem_req_ready = 1'b0;
        #1;
        checkOutput("wb_done_mem", mem_req_valid, 1'b0);
        checkOutput("wb_no_resp", N'(bus_resp_valid), '0);

        // Reset while waiting on memory, then a stale response shows up.
        $display("[TB] reset during MEM_WAIT");
        applyStimulus(1, BUS_RD, 'h100, '0);
        step();
        bus_req_valid[1] = 1'b0;
        step();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        reset         = 1'b1;
        #1;
        checkOutput("mw_rst_mem", mem_req_valid, 1'b0);
        step();
        reset          = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = DATA_FF;
        #1;
        checkOutput("mw_after_mem", mem_req_valid, 1'b0);
        checkOutput("mw_after_data", bus_resp_data, '0);
        step();
        mem_resp_valid = 1'b0;
        #1;
        checkOutput("mw_late_no_resp", N'(bus_resp_valid), '0);
        checkOutput("mw_late_data", bus_resp_data, '0);
        checkOutput("mw_late_shared", bus_resp_shared, 1'b0);
        applyStimulus(0, BUS_UPGR, 'h0, '0);
        applyStimulus(3, BUS_UPGR, 'h0, '0);
        #1;
        checkOutput("mw_ptr_reset", N'(bus_req_ready), N'(4'b0001));
        step();
        bus_req_valid = '0;
        step();
        step();

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
- Shared coherence bus between NUM_CORES L1 controllers and the memory/L2 side; sits directly downstream of each L1 controller's bus request/response channels.
- Round-robin grants one request at a time, broadcasts a snoop to the peer L1 caches and applies MOESI peer transitions.
- Sources fill data from an owning peer (M/O) or from memory, and returns data plus the shared flag to the requester.

Parameters:
- NUM_CORES, 4, number of L1 controllers on the bus (≥2).
- CORE_ID_BITS, $clog2(NUM_CORES), width of the grant index (derived; do not override).

Ports:
- clk  in  1  bus clock
- reset  in  1  synchronous, active-high reset
- bus_req_valid  in  NUM_CORES  per-core request valid
- bus_req_ready  out  NUM_CORES  per-core one-cycle accept pulse
- bus_req_addr  in  NUM_CORES×LINE_ADDR  per-core line address; LINE_ADDR = `ADDR_BITS-`OFFSET_BITS
- bus_req  in  NUM_CORES×bus_req_t  per-core op: BUS_RD, BUS_RDX, BUS_UPGR, BUS_WB
- bus_req_data  in  NUM_CORES×`CACHELINE_BITS  write-back data
- bus_resp_valid  out  NUM_CORES  one-cycle response pulse to requester
- bus_resp_data  out  `CACHELINE_BITS  fill data, broadcast
- bus_resp_shared  out  1  line is held by a peer after this fill
- snoop_valid  out  1  snoop lookup strobe
- snoop_addr  out  LINE_ADDR  snooped line address
- snoop_state  in  NUM_CORES×l1_state_t  peer line state for snoop_addr, returned in the same cycle
- snoop_data  in  NUM_CORES×`CACHELINE_BITS  peer line data, returned in the same cycle
- snoop_update  out  NUM_CORES  peer state-write enable
- snoop_next_state  out  NUM_CORES×l1_state_t  new peer state
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts
- mem_req_write  out  1  1 = write-back, 0 = read
- mem_req_addr  out  LINE_ADDR  memory line address
- mem_req_data  out  `CACHELINE_BITS  write data
- mem_resp_valid  in  1  read data valid
- mem_resp_data  in  `CACHELINE_BITS  read data

Behaviour:
- Reset: all outputs 0, FSM IDLE, round-robin pointer 0, capture registers cleared. Reset mid-transaction abandons it. mem_resp_valid outside MEM_WAIT is ignored.
- FSM states: IDLE, SNOOP, MEM_REQ, MEM_WAIT, RESPOND.
- IDLE:
  - Grant the first valid core at or after the pointer, scanning upward with wrap.
  - In the same cycle, pulse bus_req_ready[g] and capture g, addr, op and data.
  - Set pointer = (g+1) mod NUM_CORES.
  - Next state is MEM_REQ for BUS_WB, otherwise SNOOP.
  - No valid request: stay in IDLE.
- SNOOP (exactly 1 cycle):
  - Drive snoop_valid=1 and snoop_addr = captured addr.
  - Assert snoop_update[i] for every i≠g; snoop_update[g] is always 0.
  - BUS_RD peer transitions: M→O, E→S, O→O, S→S, I→I.
  - BUS_RD shared flag: set if any peer state ≠ I.
  - BUS_RDX and BUS_UPGR: all peers → I; shared flag is 0.
  - Owner = the lowest-index peer in M or O (at most one by protocol).
  - BUS_UPGR → IDLE.
  - RD/RDX with an owner: latch that owner's snoop_data → RESPOND.
  - RD/RDX without an owner → MEM_REQ.
- MEM_REQ:
  - Hold mem_req_valid with addr/data/write constant until mem_req_ready.
  - On the handshake: BUS_WB → IDLE; read → MEM_WAIT.
- MEM_WAIT: on mem_resp_valid, latch mem_resp_data → RESPOND.
- RESPOND (1 cycle):
  - bus_resp_valid[g]=1.
  - bus_resp_data = latched data; bus_resp_shared = latched flag.
  - Next state IDLE.
- Latency, unloaded bus with a zero-wait memory ready:
  - Requester's ready pulse is in cycle 0.
  - Owner fill: response at cycle 2.
  - Memory fill: response at cycle 3 + memory latency.
- Only one transaction is in flight. Requests not granted are held by the L1 until ready.
- bus_resp_data/bus_resp_shared hold their last value outside RESPOND.

Optional Feature:
- BUS_STATS_EN defined adds three outputs, each 32-bit and saturating, cleared by reset:
  - stat_txn: +1 per grant.
  - stat_c2c: +1 per owner-sourced fill.
  - stat_mem_rd: +1 per memory read.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- cache.svh package holds bus_req_t, l1_state_t (I,S,E,O,M) and the snoop-transition function peer_next_state(op, state).
- The FSM state typedef stays local.
- One sub-module: rr_arbiter.
  - Inputs: req vector, pointer, advance.
  - Outputs: grant index, grant valid.

Test Plan:
- Core0 BUS_RD 0x40, all peers I, memory returns 0xAA…: ready0 at cycle 0; no snoop_update asserted except peers I→I; resp_valid0 with data 0xAA…, shared=0.
- Core1 BUS_RD 0x40, core0 in M with data 0x55…: core0 updated to O; core1 receives 0x55… at cycle 2, shared=1; no mem_req_valid.
- Core2 BUS_RDX 0x80, cores 0/1 in S: both updated to I, memory read issued, resp shared=0. BUS_UPGR from core3: peers → I, no bus_resp_valid.
- All 4 cores valid simultaneously: grant order 0,1,2,3. Then core1 and core3 re-request: grant order 1 then 3, per the pointer.
- Core0 BUS_WB 0xC0 data 0x12…, mem_req_ready low for 3 cycles: mem_req_* stable throughout, then write accepted; no snoop, no response.
- reset pulsed during MEM_WAIT, then a late mem_resp_valid arrives: all outputs 0, no bus_resp_valid.
